ofifo_col_sync: RTL and testbench
=================================

// Module: ofifo_col_sync
// PURPOSE
//  Output FIFO directly downstream of the MAC array's last row. Captures the per-column
//  psums (out_s) with their per-column valid strobes. The strobes arrive skewed by one cycle
//  per column. Each column is buffered in its own circular queue; one row (all columns)
//  is released only once every column holds data, which re-aligns the skewed outputs.
//  Feeds the SFU / psum memory write path through a rd/o_valid handshake.
// PARAMETERS
//  col      8   number of array columns (independent queues)
//  psum_bw  16  width of one column psum
//  depth    64  entries per column queue; power of two, >=2
// PORTS
//  clk        in   1            rising-edge clock (single clock domain)
//  reset      in   1            synchronous, active-low: sampled at posedge, reset==0 clears state
//  in         in   psum_bw*col  column psums; column i = in[psum_bw*(i+1)-1 : psum_bw*i]
//  wr         in   col          per-column write strobe (array valid[i])
//  rd         in   1            pop request for one full row
//  out        out  psum_bw*col  head entry of every column (first-word-fall-through)
//  o_valid    out  1            every column queue non-empty; out holds a complete row
//  o_full     out  1            at least one column queue holds depth entries
//  o_ready    out  1            ~o_full; upstream may issue execute instructions
//  o_overflow out  1            sticky: a write was dropped on a full column
//  o_count    out  clog2(depth)+1  occupancy of the fullest column
// BEHAVIOUR
//  - Storage: col x depth x psum_bw array. Per-column wr_ptr[i] and one shared rd_ptr.
//    Pointers are clog2(depth)+1 bits. Index = low bits. Extra MSB separates full from empty.
//  - Reset (reset==0 at posedge): all wr_ptr and rd_ptr = 0, o_overflow = 0.
//    Resulting outputs: o_valid=0, o_full=0, o_ready=1, o_count=0.
//    Memory contents are not cleared. out shows stale data and is don't-care while o_valid=0.
//    Reset mid-operation discards all queued rows within the same edge. Any wr/rd in that
//    cycle is ignored.
//  - Column status: empty_i = (wr_ptr[i]==rd_ptr); full_i = low bits equal and MSBs differ.
//  - Pop: pop = rd & o_valid. On pop, rd_ptr increments by 1 (wraps mod 2*depth).
//    rd while o_valid=0 is ignored, with no side effect.
//  - Push column i: push_i = wr[i] & (~full_i | pop).
//    A full column accepts a write in the same cycle as a pop, so occupancy stays at depth.
//    On push_i, mem[i][wr_ptr[i] idx] <= in column i, and wr_ptr[i] increments.
//  - Drop: wr[i] & full_i & ~pop discards the data and sets o_overflow=1 the next cycle.
//    o_overflow holds until reset.
//  - Latency: a write at edge N is visible in out and counted in o_valid/o_count after edge N.
//    With all columns empty, the row completes one cycle after the last-column write, so
//    o_valid rises that cycle.
//  - out = combinational read of mem[i][rd_ptr idx] for every column. It updates right after
//    the pop edge.
//  - o_count = max over i of (wr_ptr[i]-rd_ptr), width clog2(depth)+1, range 0..depth.
//    o_full = (o_count==depth). o_valid = &(~empty_i). Both are combinational from registers.
//  - Pointer wrap-around must be seamless. Row order is strictly FIFO per column; rows are
//    never interleaved or reordered.
//  - Simultaneous events: pop and per-column pushes resolve in one edge. A column at
//    occupancy 1 with push and pop in the same cycle stays at 1 and keeps o_valid high.
// TESTING
//  1 Reset: drive reset=0 two cycles with wr=8'hFF, rd=1 -> o_valid=0, o_full=0, o_ready=1,
//    o_count=0, o_overflow=0.
//  2 Skewed fill: wr[i] pulses at cycle t+i, col i data = 16'h0100+i
//    -> o_valid rises at t+8. out = {16'h0107,...,16'h0100}.
//    rd=1 for one cycle -> o_valid=0, o_count=0.
//  3 Full/overflow: fill all columns 64 rows (data=row idx) -> o_full=1, o_ready=0, o_count=64.
//    Next wr=8'hFF with rd=0 -> o_overflow=1, o_count still 64.
//    Pop 64 rows -> out sequence 0..63, no row 64 data.
//  4 Full + simultaneous: at o_count=64 apply wr=8'hFF (data 16'hBEEF) with rd=1
//    -> o_count stays 64. Last row popped out equals 16'hBEEF in all columns. o_overflow=0.
//  5 Wrap-around: stream 200 rows with continuous 8-cycle skew, rd asserted whenever o_valid
//    -> rows emerge in order 0..199, o_full never set, scoreboard match per column.
//  6 Mid-op reset: with 10 rows queued, assert reset=0 for one cycle -> o_valid=0, o_count=0.
//    The next skewed row written pops back as the first row out.

Source files
------------

// File: rtl/ofifo_col_sync_if.sv
// Handshake/data bundle between the MAC-array output FIFO and its neighbours.
// The master side drives the column psums, the write strobes and the row pop request.
// The slave side (the FIFO) returns the aligned head row and the status flags.
interface ofifo_col_sync_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
);
  localparam int CW = $clog2(depth) + 1;

  logic [psum_bw*col-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [psum_bw*col-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;
  logic                   o_overflow;
  logic [CW-1:0]          o_count;

  modport master (
    output in, wr, rd,
    input  out, o_valid, o_full, o_ready, o_overflow, o_count
  );

  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_full, o_ready, o_overflow, o_count
  );
endinterface

// File: rtl/ofifo_col_sync.sv
// Output FIFO behind the MAC array's last row.
// Each column has its own circular queue and write pointer. All columns share one read
// pointer, so a row is only released once every column holds data. This re-aligns the
// one-cycle-per-column skew of the array outputs. The head row is shown first-word-fall-through.
module ofifo_col_sync #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                clk,
  input  logic                reset,
  ofifo_col_sync_if.slave     bus
);
  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;

  // The extra pointer MSB tells a full queue apart from an empty one.
  logic [PW-1:0]      wr_ptr_q [col];
  logic [PW-1:0]      wr_ptr_d [col];
  logic [PW-1:0]      rd_ptr_q;
  logic [PW-1:0]      rd_ptr_d;
  logic               overflow_q;
  logic               overflow_d;

  // Memory contents are never cleared; the pointers alone define what is valid.
  logic [psum_bw-1:0] mem_q [col][depth];

  logic [col-1:0]     empty;
  logic [col-1:0]     full;
  logic [col-1:0]     push;
  logic [col-1:0]     drop;
  logic [PW-1:0]      occ [col];
  logic [PW-1:0]      count;
  logic               row_valid;
  logic               pop;

  // Per-column occupancy and empty/full status.
  always_comb begin
    for (int i = 0; i < col; i++) begin
      occ[i]   = wr_ptr_q[i] - rd_ptr_q;
      empty[i] = (wr_ptr_q[i] == rd_ptr_q);
      full[i]  = (wr_ptr_q[i][AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[i][AW] != rd_ptr_q[AW]);
    end
  end

  // Row handshake: a pop frees a slot in time for a same-cycle write into a full column.
  always_comb begin
    row_valid = &(~empty);
    pop       = bus.rd & row_valid;
    push      = '0;
    drop      = '0;
    for (int i = 0; i < col; i++) begin
      push[i] = bus.wr[i] & (~full[i] | pop);
      drop[i] = bus.wr[i] & full[i] & ~pop;
    end
  end

  // Fullest column defines the reported occupancy.
  always_comb begin
    count = '0;
    for (int i = 0; i < col; i++) begin
      if (occ[i] > count) count = occ[i];
    end
  end

  // Next-state pointers and the sticky overflow flag.
  always_comb begin
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    for (int i = 0; i < col; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + {{AW{1'b0}}, push[i]};
    end
    overflow_d = overflow_q | (|drop);
  end

  // Pointer and flag registers; reset discards every queued row.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < col; i++) wr_ptr_q[i] <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < col; i++) wr_ptr_q[i] <= wr_ptr_d[i];
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Column storage writes; writes presented during reset are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < col; i++) begin
        if (push[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= bus.in[i*psum_bw +: psum_bw];
      end
    end
  end

  // Head row of every column plus status outputs.
  always_comb begin
    for (int i = 0; i < col; i++) begin
      bus.out[i*psum_bw +: psum_bw] = mem_q[i][rd_ptr_q[AW-1:0]];
    end
    bus.o_valid    = row_valid;
    bus.o_count    = count;
    bus.o_full     = (count == PW'(depth));
    bus.o_ready    = ~(count == PW'(depth));
    bus.o_overflow = overflow_q;
  end

endmodule

// File: tb/tb_ofifo_col_sync.sv
// Directed bench for the column-aligning output FIFO.
module tb_ofifo_col_sync;
  localparam int COL = 8;
  localparam int PB  = 16;
  localparam int DEP = 64;
  localparam int W   = COL * PB;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  ofifo_col_sync_if #(.col(COL), .psum_bw(PB), .depth(DEP)) bus ();

  ofifo_col_sync #(.col(COL), .psum_bw(PB), .depth(DEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rowv(input logic [PB-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*PB +: PB] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] colv(input logic [PB-1:0] base);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*PB +: PB] = base + PB'(i);
    return r;
  endfunction

  task automatic fill_rows(input int n, input bit idx_data);
    for (int r = 0; r < n; r++) begin
      bus.wr = '1;
      bus.in = rowv(idx_data ? PB'(r) : 16'h5A5A);
      tick();
    end
    bus.wr = '0;
  endtask

  task automatic skew_row(input logic [PB-1:0] base);
    for (int i = 0; i < COL; i++) begin
      bus.wr = COL'(1) << i;
      bus.in = colv(base);
      tick();
      if (i == COL - 2) chk("skew_not_yet", W'(bus.o_valid), W'(0));
    end
    bus.wr = '0;
  endtask

  initial begin
    int exp_r;
    int full_seen;
    logic [W-1:0] ev;
    n_vec = 0;
    n_err = 0;

    // 1 reset with activity on the inputs
    reset  = 1'b0;
    bus.wr = '1;
    bus.rd = 1'b1;
    bus.in = rowv(16'h1234);
    tick();
    tick();
    chk("rst_valid", W'(bus.o_valid), W'(0));
    chk("rst_full", W'(bus.o_full), W'(0));
    chk("rst_ready", W'(bus.o_ready), W'(1));
    chk("rst_count", W'(bus.o_count), W'(0));
    chk("rst_ovf", W'(bus.o_overflow), W'(0));
    reset  = 1'b1;
    bus.wr = '0;
    bus.rd = 1'b0;
    tick();
    chk("rst_hold_count", W'(bus.o_count), W'(0));

    // 2 skewed fill of one row
    skew_row(16'h0100);
    chk("skew_valid", W'(bus.o_valid), W'(1));
    chk("skew_out", bus.out, {16'h0107, 16'h0106, 16'h0105, 16'h0104,
                              16'h0103, 16'h0102, 16'h0101, 16'h0100});
    chk("skew_count", W'(bus.o_count), W'(1));
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    chk("skew_pop_valid", W'(bus.o_valid), W'(0));
    chk("skew_pop_count", W'(bus.o_count), W'(0));

    // 3 fill to full, then overflow
    fill_rows(DEP, 1'b1);
    chk("full_flag", W'(bus.o_full), W'(1));
    chk("full_ready", W'(bus.o_ready), W'(0));
    chk("full_count", W'(bus.o_count), W'(64));
    chk("full_ovf0", W'(bus.o_overflow), W'(0));
    bus.wr = '1;
    bus.in = rowv(16'hDEAD);
    tick();
    bus.wr = '0;
    chk("ovf_set", W'(bus.o_overflow), W'(1));
    chk("ovf_count", W'(bus.o_count), W'(64));
    for (int r = 0; r < DEP; r++) begin
      chk($sformatf("drain_row%0d", r), bus.out, rowv(PB'(r)));
      bus.rd = 1'b1;
      tick();
    end
    bus.rd = 1'b0;
    chk("drain_valid", W'(bus.o_valid), W'(0));
    chk("drain_count", W'(bus.o_count), W'(0));
    chk("ovf_sticky", W'(bus.o_overflow), W'(1));

    // clear the sticky flag
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("ovf_cleared", W'(bus.o_overflow), W'(0));

    // 4 full with simultaneous push and pop
    fill_rows(DEP, 1'b1);
    chk("sim_pre_count", W'(bus.o_count), W'(64));
    bus.wr = '1;
    bus.rd = 1'b1;
    bus.in = rowv(16'hBEEF);
    tick();
    bus.wr = '0;
    bus.rd = 1'b0;
    chk("sim_count", W'(bus.o_count), W'(64));
    chk("sim_ovf", W'(bus.o_overflow), W'(0));
    for (int r = 1; r <= DEP; r++) begin
      chk($sformatf("sim_row%0d", r), bus.out, (r == DEP) ? rowv(16'hBEEF) : rowv(PB'(r)));
      bus.rd = 1'b1;
      tick();
    end
    bus.rd = 1'b0;
    chk("sim_empty", W'(bus.o_valid), W'(0));

    // 5 continuous skewed stream across pointer wrap
    exp_r     = 0;
    full_seen = 0;
    for (int c = 0; c < 216; c++) begin
      bus.wr = '0;
      for (int i = 0; i < COL; i++) begin
        int r;
        r = c - i;
        if (r >= 0 && r < 200) begin
          bus.wr[i] = 1'b1;
          bus.in[i*PB +: PB] = PB'((r << 4) | i);
        end
      end
      bus.rd = bus.o_valid;
      if (bus.o_valid) begin
        for (int i = 0; i < COL; i++) ev[i*PB +: PB] = PB'((exp_r << 4) | i);
        chk($sformatf("wrap_row%0d", exp_r), bus.out, ev);
        exp_r++;
      end
      if (bus.o_full) full_seen++;
      tick();
    end
    bus.wr = '0;
    bus.rd = 1'b0;
    chk("wrap_rows", W'(exp_r), W'(200));
    chk("wrap_nofull", W'(full_seen), W'(0));
    chk("wrap_empty", W'(bus.o_count), W'(0));

    // 6 reset with rows queued
    fill_rows(10, 1'b1);
    chk("mid_count", W'(bus.o_count), W'(10));
    reset  = 1'b0;
    bus.wr = '1;
    bus.in = rowv(16'hFFFF);
    tick();
    reset  = 1'b1;
    bus.wr = '0;
    chk("mid_valid", W'(bus.o_valid), W'(0));
    chk("mid_count0", W'(bus.o_count), W'(0));
    skew_row(16'h0A00);
    chk("mid_valid1", W'(bus.o_valid), W'(1));
    chk("mid_out", bus.out, colv(16'h0A00));
    chk("mid_count1", W'(bus.o_count), W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
